serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 97 +++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// through a single full-subtractor cell and a borrow register. Results are
// published together on the cycle done pulses and held until the next result.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_res, r_diff;
  logic             r_br, r_bout, r_ovf;
  logic [CW-1:0]    r_cnt;

  logic w_accept, w_last, w_ai, w_bi, w_d, w_brn;

  // start is only honoured when no operation is in flight (IDLE or DONE)
  assign w_accept = start && (r_state != RUN);
  assign w_last   = (r_cnt == LAST);
  assign w_ai     = r_a[0];
  assign w_bi     = r_b[0];

  // full-subtractor cell
  assign w_d   = w_ai ^ w_bi ^ r_br;
  assign w_brn = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // operand capture, bit-serial datapath and result publication
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_br   <= 1'b0;
      r_res  <= '0;
      r_cnt  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_br  <= bin;
      r_res <= '0;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_br  <= w_brn;
      r_res <= {w_d, r_res[WIDTH-1:1]};
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        // on the MSB cycle r_br is the borrow into the MSB, w_brn the borrow out
        r_diff <= {w_d, r_res[WIDTH-1:1]};
        r_bout <= w_brn;
        r_ovf  <= r_br ^ w_brn;
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign diff = r_diff;
  assign bout = r_bout;
  assign ovf  = r_ovf;

endmodule
